mem_scan_reader: RTL and testbench
==================================

Name: mem_scan_reader

Overview:
Sequential reader that sweeps every location of the 256-entry state RAM filled by the memory-init FSM. It issues addresses 0..2^ADDR_W-1 to a synchronous-read RAM. Each read byte is presented on a valid/ready stream for downstream consumers (decrypt core, debug readout). It optionally checks each byte against the identity pattern (data == address) and reports an error count and the first failing address.

Parameters:
ADDR_W, 8, RAM address width; the sweep covers 2^ADDR_W entries
DATA_W, 8, RAM data width; identity check compares against address[DATA_W-1:0] zero-extended

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  reset: rst, synchronous, active-high; clock clk
start  in  1  request a sweep; sampled only in IDLE
check_en  in  1  enable identity check; latched when start is accepted
mem_addr  out  ADDR_W  RAM read address
mem_rd_data  in  DATA_W  RAM q; valid one cycle after the address is registered by the RAM
out_data  out  DATA_W  byte read from RAM
out_addr  out  ADDR_W  address of out_data
out_valid  out  1  out_data/out_addr valid
out_ready  in  1  consumer accepts the beat
busy  out  1  high in every state except IDLE
finish  out  1  one-cycle pulse in DONE
err_count  out  ADDR_W+1  number of mismatches in the current or last sweep
first_err_addr  out  ADDR_W  address of the first mismatch
err_seen  out  1  at least one mismatch

Behaviour:
- Reset values: state=IDLE; mem_addr, out_data, out_addr, err_count, first_err_addr = 0; out_valid, busy, finish, err_seen = 0; latched check_en = 0.
- States: IDLE, ISSUE, WAIT, SEND, DONE.
- IDLE: if start=1, go to ISSUE. On the same edge: addr<=0, err_count<=0, err_seen<=0, first_err_addr<=0, chk<=check_en. Otherwise stay in IDLE.
- ISSUE: mem_addr=addr, held stable. The RAM registers the address at the end of this cycle. Next state is WAIT.
- WAIT: mem_rd_data is valid. On the exiting edge:
  - out_data<=mem_rd_data and out_addr<=addr.
  - If chk=1 and mem_rd_data != addr: err_count+1; on the first mismatch only, first_err_addr<=addr; err_seen<=1.
  - Next state is SEND.
- SEND: out_valid=1. out_data and out_addr are held stable while out_ready=0 (no drop, no duplicate). On out_valid&&out_ready:
  - If addr==2^ADDR_W-1, go to DONE. addr does not wrap.
  - Otherwise addr<=addr+1 and go to ISSUE.
- DONE: finish=1 for exactly one cycle, then IDLE. start during DONE is ignored.
- start in ISSUE/WAIT/SEND is ignored; no restart and no error-counter clear.
- mem_addr is driven from the addr register in all states.
- err_count is ADDR_W+1 bits wide, so 256 errors fit without saturation.
- err_count, first_err_addr and err_seen hold their values after DONE until the next accepted start or rst.
- Latency with out_ready tied to 1, edge 0 sampling start:
  - Beat n is offered in cycle 3n+3.
  - finish is high in cycle 3*2^ADDR_W+1 (769 for ADDR_W=8).
  - busy is high in cycles 1..769.
- rst mid-sweep: next cycle all outputs are at reset values and state=IDLE. Any beat in flight is dropped.
- Simultaneous rst and start: rst wins.

Decomposition:
- The shared package mem_fsm_pkg holds:
  - The state enum typedef rd_state_t (IDLE, ISSUE, WAIT, SEND, DONE).
  - Constants MEM_ADDR_W=8, MEM_DATA_W=8, MEM_DEPTH=256, shared with the init FSM and the RAM wrapper.
- Single module, no sub-module. The check logic is a comparator plus counter kept inline.

Test Plan:
- Identity RAM, check_en=1, out_ready=1, pulse start → 256 beats with out_data==out_addr=0x00..0xFF in order; beat n in cycle 3n+3; finish in cycle 769; err_count=0; err_seen=0.
- Backpressure: out_ready=0 for 5 cycles when beat 0x03 is offered → out_valid stays 1, out_data=0x03 and out_addr=0x03 stable; next accepted beat is 0x04; total beats=256.
- Corrupt RAM[0x10]=0xAA and RAM[0x80]=0x00, check_en=1 → err_count=2, first_err_addr=0x10, err_seen=1; out_data at 0x10 is 0xAA.
- Same corrupt RAM with check_en=0 → err_count=0, err_seen=0; toggling check_en mid-sweep has no effect.
- Start re-pulsed during beats 5..7 and during DONE → no restart; exactly 256 beats; one finish pulse.
- rst asserted while SEND at addr 0x64 → next cycle out_valid=0, busy=0, mem_addr=0, err_count=0; a new start sweeps again from 0x00.

Source files
------------

// File: rtl/mem_fsm_pkg.sv
// Shared definitions for the state-RAM init/scan blocks.
// Holds the scan reader state encoding and the RAM geometry constants
// used by the init FSM, the RAM wrapper and the scan reader.
package mem_fsm_pkg;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 8;
  localparam int MEM_DEPTH  = 256;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    SEND,
    DONE
  } rd_state_t;

endpackage

// File: rtl/mem_scan_reader_if.sv
// RAM read port plus output beat stream of the scan reader.
// master: the reader (drives address and beats); slave: the RAM/consumer side.
// Beats move on valid && ready; read data arrives one cycle after the address.
interface mem_scan_reader_if
  import mem_fsm_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
);

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output mem_addr,
    input  mem_rd_data,
    output out_data,
    output out_addr,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  mem_addr,
    output mem_rd_data,
    input  out_data,
    input  out_addr,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/mem_scan_reader.sv
// Sweeps every RAM location once per start, streaming (addr, data) beats and checking data == addr.
// Latency: 3 cycles per beat (issue, read, send); finish pulses 3*2^ADDR_W+1 cycles after start.
// Backpressure: the beat is held in SEND until out_ready; the sweep stalls, nothing is dropped.
module mem_scan_reader
  import mem_fsm_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                check_en,
  mem_scan_reader_if.master   bus,
  output logic                busy,
  output logic                finish,
  output logic [ADDR_W:0]     err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic                err_seen
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  rd_state_t         state;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] beat_data;
  logic [ADDR_W-1:0] beat_addr;
  logic              beat_valid;
  logic              chk;
  logic [DATA_W-1:0] ident;
  logic              mismatch;

  // Expected identity byte: the address truncated or zero-extended to the data width.
  always_comb begin
    ident    = DATA_W'(addr);
    mismatch = chk && (bus.mem_rd_data != ident);
  end

  assign bus.mem_addr  = addr;
  assign bus.out_data  = beat_data;
  assign bus.out_addr  = beat_addr;
  assign bus.out_valid = beat_valid;

  // Sweep FSM: issue address, capture read data and check it, hold beat until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      addr           <= '0;
      beat_data      <= '0;
      beat_addr      <= '0;
      beat_valid     <= 1'b0;
      busy           <= 1'b0;
      finish         <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      err_seen       <= 1'b0;
      chk            <= 1'b0;
    end else begin
      finish <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state          <= ISSUE;
            busy           <= 1'b1;
            addr           <= '0;
            err_count      <= '0;
            err_seen       <= 1'b0;
            first_err_addr <= '0;
            chk            <= check_en;
          end
        end
        ISSUE: begin
          // RAM registers addr at the end of this cycle.
          state <= WAIT;
        end
        WAIT: begin
          beat_data  <= bus.mem_rd_data;
          beat_addr  <= addr;
          beat_valid <= 1'b1;
          if (mismatch) begin
            err_count <= err_count + 1'b1;
            err_seen  <= 1'b1;
            if (!err_seen) begin
              first_err_addr <= addr;
            end
          end
          state <= SEND;
        end
        SEND: begin
          if (bus.out_ready) begin
            beat_valid <= 1'b0;
            if (addr == LAST_ADDR) begin
              state  <= DONE;
              finish <= 1'b1;
            end else begin
              addr  <= addr + 1'b1;
              state <= ISSUE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_scan_reader.sv
// Scoreboard bench for mem_scan_reader: stimulus queues expected beats, a monitor pops and compares.
// Covers reset, identity sweep, backpressure, corrupted RAM with/without check, start re-pulses,
// and reset mid-sweep followed by a fresh sweep.
module tb_mem_scan_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       check_en;
  logic       busy;
  logic       finish;
  logic [8:0] err_count;
  logic [7:0] first_err_addr;
  logic       err_seen;

  mem_scan_reader_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  mem_scan_reader #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .check_en       (check_en),
    .bus            (bus),
    .busy           (busy),
    .finish         (finish),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .err_seen       (err_seen)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } beat_t;

  beat_t      q[$];
  logic [7:0] ram[256];
  int         cyc = 0;
  int         base = 0;
  int         checks = 0;
  int         failures = 0;

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic [7:0] prev_addr;

  // Synchronous-read RAM model.
  always @(posedge clk) bus.mem_rd_data <= ram[bus.mem_addr];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted beat and checks stall stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("stall_valid", int'(bus.out_valid), 1);
        check_eq("stall_data", int'(bus.out_data), int'(prev_data));
        check_eq("stall_addr", int'(bus.out_addr), int'(prev_addr));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: addr 0x%0h data 0x%0h with empty scoreboard",
                   bus.out_addr, bus.out_data);
        end else begin
          beat_t e;
          e = q.pop_front();
          check_eq("beat_addr", int'(bus.out_addr), e.addr);
          check_eq("beat_data", int'(bus.out_data), e.data);
          check_eq("beat_cycle", cyc - base + 1, e.cyc);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_addr  = bus.out_addr;
    end
  end

  // mode: 0 identity, 1 backpressure, 2 corrupt+check, 3 corrupt no check,
  //       4 start re-pulses, 5 reset mid-sweep
  task automatic run_sweep(input int mode);
    bit corrupt;
    bit chk;
    int n_beats;
    int exp_fin;
    int fin_cnt;
    int fin_rel;
    bit busy_ok;
    corrupt = (mode == 2) || (mode == 3) || (mode == 5);
    chk     = (mode != 3);
    n_beats = (mode == 5) ? 100 : 256;
    exp_fin = (mode == 1) ? 774 : 769;
    fin_cnt = 0;
    fin_rel = 0;
    busy_ok = 1'b1;

    for (int i = 0; i < 256; i++) ram[i] = 8'(i);
    if (corrupt) begin
      ram[8'h10] = 8'hAA;
      ram[8'h80] = 8'h00;
    end
    for (int n = 0; n < n_beats; n++) begin
      beat_t b;
      b.addr = n;
      b.data = int'(ram[n]);
      if (mode == 1) b.cyc = (n < 3) ? 3*n + 3 : (n == 3) ? 17 : 3*n + 8;
      else           b.cyc = 3*n + 3;
      q.push_back(b);
    end

    @(posedge clk); #1;
    check_en  = chk;
    bus.out_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    base  = cyc;
    start = 1'b0;

    for (int rel = 1; rel <= 1500; rel++) begin
      // Drives for cycle rel.
      if (mode == 1 && rel == 12) bus.out_ready = 1'b0;
      if (mode == 1 && rel == 17) bus.out_ready = 1'b1;
      if (mode == 3 && rel == 50) check_en = 1'b1;
      if (mode == 3 && rel == 400) check_en = 1'b0;
      if (mode == 4 && (rel == 18 || rel == 769)) start = 1'b1;
      if (mode == 4 && (rel == 25 || rel == 770)) start = 1'b0;
      if (mode == 5 && rel == 303) begin
        bus.out_ready = 1'b0;
        rst = 1'b1;
      end
      @(negedge clk);
      if (mode == 5 && rel == 304) begin
        check_eq("rst_out_valid", int'(bus.out_valid), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_mem_addr", int'(bus.mem_addr), 0);
        check_eq("rst_err_count", int'(err_count), 0);
        check_eq("rst_err_seen", int'(err_seen), 0);
        check_eq("rst_finish", int'(finish), 0);
        check_eq("rst_beats_left", q.size(), 0);
        break;
      end
      if (busy !== (fin_cnt == 0)) busy_ok = 1'b0;
      if (finish) begin
        fin_cnt++;
        fin_rel = rel;
      end
      if (fin_cnt > 0 && rel >= fin_rel + 3) break;
      @(posedge clk); #1;
    end

    if (mode == 5) begin
      @(posedge clk); #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
    end else begin
      check_eq("finish_pulses", fin_cnt, 1);
      check_eq("finish_cycle", fin_rel, exp_fin);
      check_eq("busy_window", int'(busy_ok), 1);
      check_eq("beats_left", q.size(), 0);
      check_eq("err_count", int'(err_count), (corrupt && chk) ? 2 : 0);
      check_eq("err_seen", int'(err_seen), (corrupt && chk) ? 1 : 0);
      check_eq("first_err_addr", int'(first_err_addr), (corrupt && chk) ? 'h10 : 0);
    end
    q.delete();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i);
    rst           = 1'b1;
    start         = 1'b1;
    check_en      = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_busy", int'(busy), 0);
    check_eq("reset_out_valid", int'(bus.out_valid), 0);
    check_eq("reset_finish", int'(finish), 0);
    check_eq("reset_mem_addr", int'(bus.mem_addr), 0);
    check_eq("reset_out_data", int'(bus.out_data), 0);
    check_eq("reset_out_addr", int'(bus.out_addr), 0);
    check_eq("reset_err_count", int'(err_count), 0);
    check_eq("reset_first_err", int'(first_err_addr), 0);
    check_eq("reset_err_seen", int'(err_seen), 0);
    @(posedge clk); #1;
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_eq("idle_busy", int'(busy), 0);

    run_sweep(0);
    run_sweep(1);
    run_sweep(2);
    run_sweep(3);
    run_sweep(4);
    run_sweep(5);
    run_sweep(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
